// File: rtl/wav_rec_pkg.sv
// Shared types and helpers for the wav_recorder capture block: FSM state
// encoding, the default sample-rate divider and the 16-bit to 8-bit PCM conversion.
package wav_rec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int DEFAULT_PRESCALE = 3000;

  // Keep the top byte; flipping the MSB of a signed sample turns it into offset-binary.
  function automatic logic [7:0] to_u8(input logic [15:0] sample, input logic signed_f);
    return {sample[15] ^ signed_f, sample[14:8]};
  endfunction

endpackage

// File: rtl/wav_recorder_rate_tick.sv
// rate_tick: free-running divider that counts 0..PRESCALE-1 while enabled and
// flags the last count with a one-cycle tick. A synchronous clear parks it at 0.
module rate_tick #(
  parameter int PRESCALE = 3000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wav_recorder.sv
// wav_recorder: captures the 16-bit audio bus at a fixed sample rate and writes
// 8-bit unsigned PCM into sample RAM. Define WAV_REC_LOOP_EN for ring-buffer capture.
module wav_recorder
  import wav_rec_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [15:0]       i_sample,
  input  logic              i_sample_signed,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic [7:0]        o_ram_d,
  output logic              o_ram_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_full,
  output logic [ADDR_W:0]   o_len
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W + 1)'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_d_q, ram_d_d;
  logic              tick;

  // Divider is held at 0 outside CAPTURE, so entering CAPTURE always starts a full period.
  rate_tick #(.PRESCALE(PRESCALE)) u_rate_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != CAPTURE),
    .en      (state_q == CAPTURE),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    full_d  = full_q;
    done_d  = done_q;
    we_d    = 1'b0;
    ram_a_d = ram_a_q;
    ram_d_d = ram_d_q;

    case (state_q)
      IDLE, DONE: begin
        if (i_start && !i_stop) begin
          state_d = CAPTURE;
          addr_d  = '0;
          len_d   = '0;
          full_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      CAPTURE: begin
        if (tick) begin
          we_d    = 1'b1;
          ram_a_d = addr_q;
          ram_d_d = to_u8(i_sample, i_sample_signed);
          addr_d  = addr_q + 1'b1;
`ifdef WAV_REC_LOOP_EN
          len_d   = (len_q == DEPTH) ? len_q : len_q + 1'b1;
          if (addr_q == ADDR_MAX) full_d = 1'b1;
`else
          len_d   = len_q + 1'b1;
          if (addr_q == ADDR_MAX) begin
            full_d  = 1'b1;
            state_d = DONE;
            done_d  = 1'b1;
          end
`endif
        end
        // A stop on the tick cycle still lets that tick's write through.
        if (i_stop) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      ram_a_q <= '0;
      ram_d_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      full_q  <= full_d;
      done_q  <= done_d;
      we_q    <= we_d;
      ram_a_q <= ram_a_d;
      ram_d_q <= ram_d_d;
    end
  end

  assign o_ram_a  = ram_a_q;
  assign o_ram_d  = ram_d_q;
  assign o_ram_we = we_q;
  assign o_busy   = (state_q == CAPTURE);
  assign o_done   = done_q;
  assign o_full   = full_q;
  assign o_len    = len_q;

endmodule
